// File: rtl/sw_time_seq.sv
// sw_time_seq: 100 Hz time base and BCD time datapath for the stopwatch.
// A prescaler divides clk_i down to a hundredth-second tick. Each tick advances a four-digit
// BCD time register (SS.hh, 00.00-59.99). A two-state display FSM freezes a lap value on
// split rising edges.
//
// Ports:
//   clk_i           system clock, rising-edge active
//   reset_i         asynchronous active-high reset
//   init_regs_i     synchronous clear from the control FSM (beats counting and split)
//   count_enabled_i counting advances only while high
//   split_i         debounced split level, acted on at its rising edge
//   time_bcd_o      live time {tens of s, s, tenths, hundredths}
//   disp_bcd_o      lap register while frozen, else time_bcd_o
//   frozen_o        display is showing a captured lap
//   tick_o          one-cycle pulse in the cycle after the digits advance
//   wrap_o          one-cycle pulse with tick_o when time rolled 59.99 -> 00.00
module sw_time_seq #(
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        init_regs_i,
  input  logic        count_enabled_i,
  input  logic        split_i,
  output logic [15:0] time_bcd_o,
  output logic [15:0] disp_bcd_o,
  output logic        frozen_o,
  output logic        tick_o,
  output logic        wrap_o
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] PrescMax = CntW'(TICK_DIV - 1);

  typedef enum logic [0:0] {StLive, StFrozen} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] presc_q, presc_d;
  logic [15:0]     time_q, time_d;
  logic [15:0]     lap_q, lap_d;
  logic            split_q, split_d;
  logic            tick_q, tick_d;
  logic            wrap_q, wrap_d;

  logic            split_rise;
  logic [3:0]      d0, d1, d2, d3;

  assign split_rise = split_i & ~split_q;

  // BCD increment of the live time; rolls on ">=" so a corrupted digit still returns to 0.
  always_comb begin
    d0 = time_q[3:0];
    d1 = time_q[7:4];
    d2 = time_q[11:8];
    d3 = time_q[15:12];
    if (d0 >= 4'd9) begin
      d0 = 4'd0;
      if (d1 >= 4'd9) begin
        d1 = 4'd0;
        if (d2 >= 4'd9) begin
          d2 = 4'd0;
          if (d3 >= 4'd5) d3 = 4'd0;
          else            d3 = d3 + 4'd1;
        end else begin
          d2 = d2 + 4'd1;
        end
      end else begin
        d1 = d1 + 4'd1;
      end
    end else begin
      d0 = d0 + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    time_d  = time_q;
    lap_d   = lap_q;
    split_d = split_i;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;

    if (init_regs_i) begin
      state_d = StLive;
      presc_d = '0;
      time_d  = '0;
      lap_d   = '0;
      split_d = 1'b0;
    end else begin
      if (count_enabled_i) begin
        if (presc_q == PrescMax) begin
          presc_d = '0;
          time_d  = {d3, d2, d1, d0};
          tick_d  = 1'b1;
          wrap_d  = (time_q == 16'h5999);
        end else begin
          presc_d = presc_q + CntW'(1);
        end
      end
      // Split while paused belongs to the control FSM and is ignored here.
      if (split_rise && count_enabled_i) begin
        unique case (state_q)
          StLive: begin
            state_d = StFrozen;
            lap_d   = time_q;  // value before any same-edge advance
          end
          StFrozen: state_d = StLive;
          default:  state_d = StLive;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StLive;
      presc_q <= '0;
      time_q  <= '0;
      lap_q   <= '0;
      split_q <= 1'b0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      time_q  <= time_d;
      lap_q   <= lap_d;
      split_q <= split_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign time_bcd_o = time_q;
  assign frozen_o   = (state_q == StFrozen);
  assign disp_bcd_o = frozen_o ? lap_q : time_q;
  assign tick_o     = tick_q;
  assign wrap_o     = wrap_q;

endmodule

// File: tb/tb_sw_time_seq.sv
module tb_sw_time_seq;
  localparam int unsigned TickDiv = 4;

  logic        clk = 1'b0;
  logic        reset, init_regs, count_en, split;
  logic [15:0] time_bcd, disp_bcd;
  logic        frozen, tick, wrap;

  int errors = 0;
  int checks = 0;
  int ticks, first_tick, wraps, wrap_ticks;
  logic [15:0] time_at_wrap;

  string       tag_q[$];
  logic [15:0] exp_q[$];

  sw_time_seq #(.TICK_DIV(TickDiv)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .init_regs_i    (init_regs),
    .count_enabled_i(count_en),
    .split_i        (split),
    .time_bcd_o     (time_bcd),
    .disp_bcd_o     (disp_bcd),
    .frozen_o       (frozen),
    .tick_o         (tick),
    .wrap_o         (wrap)
  );

  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [15:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [15:0] obs);
    string       t;
    logic [15:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  function automatic logic [15:0] flags();
    return {13'd0, frozen, tick, wrap};
  endfunction

  // One clock edge; outputs are then sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    if (tick) ticks++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic init_pulse();
    init_regs = 1'b1;
    step();
    init_regs = 1'b0;
  endtask

  initial begin
    reset = 1'b1; init_regs = 1'b0; count_en = 1'b0; split = 1'b0;
    ticks = 0;
    repeat (2) @(negedge clk);

    // 1: reset and init clear
    expect_val("reset_time", 16'h0000);  check(time_bcd);
    expect_val("reset_flags", 16'h0000); check(flags());
    reset = 1'b0;
    init_pulse();
    expect_val("init_time", 16'h0000);   check(time_bcd);
    expect_val("init_disp", 16'h0000);   check(disp_bcd);
    expect_val("init_flags", 16'h0000);  check(flags());

    // 2: 40 cycles of counting
    ticks = 0; first_tick = -1;
    count_en = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (tick && first_tick < 0) first_tick = i;
    end
    expect_val("first_tick_latency", 16'd4); check(16'(first_tick));
    expect_val("ticks_40", 16'd10);          check(16'(ticks));
    expect_val("time_40", 16'h0010);         check(time_bcd);
    count_en = 1'b0;
    step();
    expect_val("tick_after_stop", 16'h0000); check({15'd0, tick});

    // 3: pause preserves the prescaler
    init_pulse();
    ticks = 0;
    count_en = 1'b1; steps(6);
    count_en = 1'b0; steps(10);
    count_en = 1'b1; steps(2);
    count_en = 1'b0;
    expect_val("pause_ticks", 16'd2);   check(16'(ticks));
    expect_val("pause_time", 16'h0002); check(time_bcd);

    // 4: count to 59.99 and wrap
    init_pulse();
    ticks = 0;
    count_en = 1'b1;
    steps(5999 * TickDiv);
    expect_val("ticks_5999", 16'd5999);  check(16'(ticks));
    expect_val("time_5999", 16'h5999);   check(time_bcd);
    wraps = 0; wrap_ticks = 0; time_at_wrap = 16'hffff;
    for (int i = 0; i < 6; i++) begin
      step();
      if (wrap) begin
        wraps++;
        time_at_wrap = time_bcd;
        if (tick) wrap_ticks++;
      end
    end
    expect_val("wrap_count", 16'd1);      check(16'(wraps));
    expect_val("wrap_with_tick", 16'd1);  check(16'(wrap_ticks));
    expect_val("wrap_time", 16'h0000);    check(time_at_wrap);
    count_en = 1'b0;

    // 5: split behaviour
    init_pulse();
    count_en = 1'b1;
    steps(123 * TickDiv);
    expect_val("time_0123", 16'h0123);    check(time_bcd);
    split = 1'b1;
    step();
    expect_val("split1_flags", 16'h0004); check(flags());
    expect_val("split1_disp", 16'h0123);  check(disp_bcd);
    steps(4);
    expect_val("held_frozen", 16'h0004);  check(flags());
    expect_val("held_disp", 16'h0123);    check(disp_bcd);
    expect_val("held_time", 16'h0124);    check(time_bcd);
    split = 1'b0; step();
    split = 1'b1; step();
    expect_val("split2_frozen", 16'h0000); check({15'd0, frozen});
    expect_val("split2_disp", 16'h0124);   check(disp_bcd);
    count_en = 1'b0;
    split = 1'b0; step();
    split = 1'b1; step();
    expect_val("paused_split_frozen", 16'h0000); check({15'd0, frozen});
    expect_val("paused_split_disp", 16'h0124);   check(disp_bcd);
    count_en = 1'b1;
    split = 1'b0; step();
    split = 1'b1; step();
    expect_val("split3_disp", 16'h0125);  check(disp_bcd);
    count_en = 1'b0;
    split = 1'b0; step();
    split = 1'b1; step();
    expect_val("paused_frozen_hold", 16'h0004); check({13'd0, frozen, 2'b00});
    expect_val("paused_frozen_disp", 16'h0125); check(disp_bcd);

    // 6: init while frozen and counting, then async reset mid-freeze
    split = 1'b0;
    count_en = 1'b1;
    steps(2);
    init_pulse();
    expect_val("init_frozen_time", 16'h0000);  check(time_bcd);
    expect_val("init_frozen_disp", 16'h0000);  check(disp_bcd);
    expect_val("init_frozen_flags", 16'h0000); check(flags());
    steps(4);
    split = 1'b1; step();
    steps(1);
    expect_val("refreeze_disp", 16'h0001);  check(disp_bcd);
    expect_val("refreeze_flags", 16'h0004); check(flags());
    #2 reset = 1'b1;
    #1;
    expect_val("async_time", 16'h0000);  check(time_bcd);
    expect_val("async_disp", 16'h0000);  check(disp_bcd);
    expect_val("async_flags", 16'h0000); check(flags());
    @(negedge clk);
    reset = 1'b0;
    split = 1'b0;
    steps(TickDiv);
    expect_val("resume_time", 16'h0001); check(time_bcd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sw_time_seq.md
# sw_time_seq

Time-base sequencer and BCD time datapath for the stopwatch. It sits directly under the stopwatch control FSM and consumes that FSM's `init_regs` and `count_enabled`. From those it derives a 100 Hz tick, advances a four-digit BCD time register (SS.hh, 00.00–59.99), and manages a lap-freeze register that drives the 7-segment display path.

## Interface
- `TICK_DIV`, default 1000000: clk cycles per hundredth-second tick (100 MHz / 100 Hz). Legal range ≥ 2. The prescaler width is clog2(TICK_DIV).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset; one clock domain only.
- `init_regs`  in  1  synchronous clear from the control FSM.
- `count_enabled`  in  1  level; counting advances only while high.
- `split`  in  1  level from the board (already debounced); acted on at its rising edge.
- `time_bcd`  out  16  live time: [15:12] tens of seconds (0–5), [11:8] seconds, [7:4] tenths, [3:0] hundredths.
- `disp_bcd`  out  16  display value: the lap register when frozen, otherwise `time_bcd` (combinational mux).
- `frozen`  out  1  high while the display is showing a captured lap.
- `tick`  out  1  one-cycle pulse in the cycle after the digits advance.
- `wrap`  out  1  one-cycle pulse, coincident with `tick`, when time rolled from 59.99 to 00.00.

## Operation
- **Reset.** While `reset` is high: prescaler = 0, digits = 0, lap register = 0, `split_d` = 0, `frozen`/`tick`/`wrap` = 0. All outputs are therefore 0.
- **Priority per edge:** `reset` > `init_regs` > counting/split.
- **`init_regs` = 1:** same clearing as reset, but synchronous. It overrides `count_enabled` and `split` in the same cycle.
- **Prescaler.**
  - Increments only when `count_enabled` = 1.
  - At TICK_DIV−1 it returns to 0 and the digits advance by one hundredth.
  - When `count_enabled` = 0 it holds its value, so a resumed count finishes the partial period (no restart).
- **BCD cascade.**
  - The hundredths digit rolls 9→0 with a carry into tenths.
  - Tenths rolls 9→0 with a carry into seconds.
  - Seconds rolls 9→0 with a carry into tens of seconds.
  - Tens of seconds rolls 5→0 with no carry out. A roll of all four digits asserts `wrap`.
  - No digit ever holds a non-BCD value.
- **Split edge detect.** `split_rise` = `split` & ~`split_d`, where `split_d` is registered every cycle. A held level produces exactly one event.
- **Display FSM, two states:**
  - LIVE (`frozen` = 0) → FROZEN on `split_rise` & `count_enabled`. The lap register captures the current registered `time_bcd`, i.e. the value before any advance occurring on the same edge.
  - FROZEN → LIVE on `split_rise` & `count_enabled`. The lap register keeps its value but is no longer displayed.
  - `split_rise` with `count_enabled` = 0 is ignored. In that case the control FSM owns `split` (PAUSED→IDLE), and the following `init_regs` returns this block to LIVE.
- **Counting while FROZEN.** `time_bcd`, `tick` and `wrap` keep running. Only `disp_bcd` holds.

## Timing
- **Counting latency.** With the prescaler at 0 and `count_enabled` high from edge 0, the first digit advance occurs on edge TICK_DIV−1. `tick` is high during the cycle that follows. The steady-state tick period is TICK_DIV cycles.
- **`wrap`** is asserted in the same cycle as the `tick` that follows the 59.99→00.00 edge.
- **`split`.** A rising `split` sampled at edge N updates `frozen` and the lap register at edge N. `disp_bcd` reflects the change in cycle N+1 after the edge, with no further latency.
- **`init_regs`** sampled at edge N: all outputs are 0 after edge N. A pending `tick`/`wrap` is cancelled.
- **`reset`** clears immediately (asynchronously), including mid-count and mid-freeze. Counting can resume on the first edge after deassertion if `count_enabled` is high.

## Test plan
All scenarios use TICK_DIV = 4.
1. Pulse `reset`, then pulse `init_regs` for 1 cycle → `time_bcd` = `disp_bcd` = 16'h0000; `frozen` = `tick` = `wrap` = 0.
2. From clear, hold `count_enabled` = 1 for 40 cycles → `tick` pulses every 4th cycle, 10 pulses in total; `time_bcd` = 16'h0010.
3. From clear, `count_enabled` high for 6 cycles, low for 10, high for 2 → exactly 2 ticks and `time_bcd` = 16'h0002; the prescaler value is preserved across the pause.
4. Count to 59.99 (5999 ticks), then 1 more tick → `time_bcd` = 16'h0000, with `wrap` and `tick` high together for exactly one cycle.
5. Split behaviour:
   - At `time_bcd` = 16'h0123, raise `split` and hold it 5 cycles → one toggle; `frozen` = 1, `disp_bcd` stays 16'h0123 while `time_bcd` advances.
   - A second `split` rising edge → `frozen` = 0 and `disp_bcd` equals `time_bcd`.
   - A `split` rising edge with `count_enabled` = 0 → no change.
6. While frozen and counting, assert `init_regs` → next cycle all outputs 0 and `frozen` = 0. Repeat with asynchronous `reset` mid-cycle → outputs are 0 before the next clock edge.
